// File: rtl/tnn_serial_neuron_if.sv
// Stream bundle for tnn_serial_neuron: activation input, decision output and
// the per-vector control signals (threshold, abort).
interface tnn_serial_neuron_if #(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned ACC_W = 6
);
    logic             clear;
    logic [ACC_W-1:0] thr;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic [ACC_W-1:0] out_acc;

    modport master (
        output clear, thr, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bit, out_acc
    );

    modport slave (
        input  clear, thr, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bit, out_acc
    );
endinterface

// File: rtl/tnn_serial_neuron.sv
// Serial ternary-weight threshold neuron: accumulates N_IN weighted activations
// with saturation and emits one decision bit (sum > thr) per vector.
module tnn_serial_neuron #(
    parameter int unsigned      IN_W    = 2,
    parameter int unsigned      N_IN    = 5,
    parameter int unsigned      ACC_W   = 6,
    parameter logic [2*N_IN-1:0] WEIGHTS = 10'h1F5
) (
    input  logic clk,
    input  logic rst,
    tnn_serial_neuron_if.slave bus
);
    localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        ST_ACC,
        ST_DONE
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc;

    logic [1:0]              wcode;
    logic [ACC_W:0]          ext;
    logic signed [ACC_W:0]   term;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] acc_next;

    assign bus.in_ready = (state == ST_ACC) && !rst;

    // Weight lookup, signed term and saturating add for the current element.
    always_comb begin
        wcode = 2'b00;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (idx == IDX_W'(i)) begin
                wcode = WEIGHTS[2*i +: 2];
            end
        end
        ext = (ACC_W+1)'(bus.in_data);
        case (wcode)
            2'b01:   term = ext;
            2'b11:   term = -ext;
            default: term = '0;
        endcase
        sum = {acc[ACC_W-1], acc} + term;
        if (sum > SAT_MAX) begin
            acc_next = ACC_W'(SAT_MAX);
        end else if (sum < SAT_MIN) begin
            acc_next = ACC_W'(SAT_MIN);
        end else begin
            acc_next = ACC_W'(sum);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_ACC;
            idx           <= '0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_bit   <= 1'b0;
            bus.out_acc   <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (bus.clear) begin
                        acc <= '0;
                        idx <= '0;
                    end else if (bus.in_valid) begin
                        if (idx == LAST_IDX) begin
                            state         <= ST_DONE;
                            bus.out_valid <= 1'b1;
                            bus.out_acc   <= acc_next;
                            bus.out_bit   <= (acc_next > $signed(bus.thr));
                            acc           <= '0;
                            idx           <= '0;
                        end else begin
                            acc <= acc_next;
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Result holds until consumed; clear is ignored here.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_tnn_serial_neuron.sv
// Scoreboard bench: one stimulus stream drives a default neuron and an ACC_W=4
// neuron; a vector-level model predicts each decision.
module tb_tnn_serial_neuron;
    localparam int N_IN = 5;
    localparam logic [9:0] WTS = 10'h1F5;

    typedef struct {
        int acc;
        bit b;
    } res_t;

    bit         clk;
    logic       rst_v       = 1'b1;
    logic       clear_v     = 1'b0;
    logic       in_valid_v  = 1'b0;
    logic       out_ready_v = 1'b1;
    logic [1:0] in_data_v   = 2'd0;
    int         thr_v       = 0;

    res_t expq[2][$];
    int   elems[$];
    bit   pending;
    bit   accepted;
    int   total;
    int   passed;

    tnn_serial_neuron_if #(.IN_W(2), .ACC_W(6)) bus0 ();
    tnn_serial_neuron_if #(.IN_W(2), .ACC_W(4)) bus1 ();

    assign bus0.clear     = clear_v;
    assign bus0.thr       = 6'(thr_v);
    assign bus0.in_valid  = in_valid_v;
    assign bus0.in_data   = in_data_v;
    assign bus0.out_ready = out_ready_v;
    assign bus1.clear     = clear_v;
    assign bus1.thr       = 4'(thr_v);
    assign bus1.in_valid  = in_valid_v;
    assign bus1.in_data   = in_data_v;
    assign bus1.out_ready = out_ready_v;

    tnn_serial_neuron #(.IN_W(2), .N_IN(5), .ACC_W(6), .WEIGHTS(WTS)) u0 (
        .clk (clk),
        .rst (rst_v),
        .bus (bus0)
    );

    tnn_serial_neuron #(.IN_W(2), .N_IN(5), .ACC_W(4), .WEIGHTS(WTS)) u1 (
        .clk (clk),
        .rst (rst_v),
        .bus (bus1)
    );

    initial forever #5 clk = ~clk;

    function automatic res_t model(input int e[$], input int accw, input int thr);
        res_t r;
        int   s  = 0;
        int   hi = (1 << (accw - 1)) - 1;
        int   lo = -(1 << (accw - 1));
        int   c;
        for (int i = 0; i < N_IN; i++) begin
            c = int'((WTS >> (2 * i)) & 10'd3);
            if (c == 1) s = s + e[i];
            else if (c == 3) s = s - e[i];
            if (s > hi) s = hi;
            if (s < lo) s = lo;
        end
        r.acc = s;
        r.b   = (s > thr);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Protocol model, evaluated at each rising edge on the inputs held there.
    task automatic model_edge();
        accepted = 1'b0;
        if (rst_v) begin
            if (pending && !out_ready_v) begin
                void'(expq[0].pop_front());
                void'(expq[1].pop_front());
            end
            pending = 1'b0;
            elems.delete();
        end else if (pending) begin
            if (out_ready_v) pending = 1'b0;
        end else if (clear_v) begin
            elems.delete();
        end else if (in_valid_v) begin
            accepted = 1'b1;
            elems.push_back(int'(in_data_v));
            if (elems.size() == N_IN) begin
                expq[0].push_back(model(elems, 6, thr_v));
                expq[1].push_back(model(elems, 4, thr_v));
                pending = 1'b1;
                elems.delete();
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input int d);
        int n = 0;
        in_valid_v = 1'b1;
        in_data_v  = 2'(d);
        accepted   = 1'b0;
        while (!accepted && n < 50) begin
            step();
            n++;
        end
        if (!accepted) check("send_timeout", 0, 1);
        in_valid_v = 1'b0;
    endtask

    task automatic vec(input int d[N_IN], input int thr);
        thr_v = thr;
        for (int i = 0; i < N_IN; i++) send(d[i]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (pending && n < 50) begin
            step();
            n++;
        end
        if (pending) check("idle_timeout", 0, 1);
    endtask

    task automatic mon(input int k, input logic rdy, input logic ov,
                       input logic ob, input int oa);
        check($sformatf("in_ready%0d", k), int'(rdy), int'(!pending && !rst_v));
        check($sformatf("out_valid%0d", k), int'(ov), int'(pending));
        if (ov === 1'b1) begin
            if (expq[k].size() == 0) begin
                check($sformatf("unexpected_out%0d", k), 1, 0);
            end else begin
                check($sformatf("out_acc%0d", k), oa, expq[k][0].acc);
                check($sformatf("out_bit%0d", k), int'(ob), int'(expq[k][0].b));
                if (out_ready_v) void'(expq[k].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.in_ready, bus0.out_valid, bus0.out_bit, int'($signed(bus0.out_acc)));
        mon(1, bus1.in_ready, bus1.out_valid, bus1.out_bit, int'($signed(bus1.out_acc)));
    end

    initial begin
        repeat (3) step();
        rst_v = 1'b0;
        step();
        check("rst_out_acc0", int'(bus0.out_acc), 0);
        check("rst_out_bit0", int'(bus0.out_bit), 0);
        check("rst_out_acc1", int'(bus1.out_acc), 0);

        vec('{3, 0, 1, 1, 0}, 0);
        vec('{1, 0, 1, 0, 0}, 0);
        vec('{1, 0, 1, 0, 0}, -1);
        wait_idle();

        // Backpressure with in_valid held and a clear that must be ignored.
        out_ready_v = 1'b0;
        vec('{2, 1, 0, 0, 3}, 5);
        in_valid_v = 1'b1;
        in_data_v  = 2'd3;
        clear_v    = 1'b1;
        step();
        clear_v = 1'b0;
        repeat (3) step();
        out_ready_v = 1'b1;
        send(3);
        for (int i = 0; i < N_IN - 1; i++) send(1);
        wait_idle();

        vec('{3, 3, 0, 0, 3}, 0);
        vec('{0, 0, 3, 3, 0}, 0);
        wait_idle();

        // Gap, then abort with a valid element present.
        thr_v = 0;
        send(2);
        step();
        send(1);
        clear_v    = 1'b1;
        in_valid_v = 1'b1;
        in_data_v  = 2'd3;
        step();
        clear_v    = 1'b0;
        in_valid_v = 1'b0;
        vec('{0, 0, 0, 0, 1}, 0);
        wait_idle();

        // Reset mid-vector, then reset while a result is pending.
        send(1);
        send(2);
        send(3);
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        vec('{0, 0, 2, 0, 0}, 0);
        wait_idle();
        out_ready_v = 1'b0;
        vec('{3, 3, 0, 0, 0}, 1);
        step();
        rst_v = 1'b1;
        step();
        rst_v       = 1'b0;
        out_ready_v = 1'b1;
        step();

        for (int c = 0; c < 600; c++) begin
            rst_v       = ($urandom_range(99) == 0);
            clear_v     = ($urandom_range(19) == 0);
            in_valid_v  = ($urandom_range(9) < 7);
            in_data_v   = 2'($urandom_range(3));
            out_ready_v = ($urandom_range(9) < 7);
            thr_v       = int'($urandom_range(15)) - 8;
            step();
        end

        rst_v       = 1'b0;
        clear_v     = 1'b0;
        in_valid_v  = 1'b0;
        out_ready_v = 1'b1;
        repeat (4) step();
        check("drain0", expq[0].size(), 0);
        check("drain1", expq[1].size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tnn_serial_neuron.md
Name: tnn_serial_neuron

Overview:
- Parametrised, sequential successor to the 5-input, 2-bit combinational ternary-weight threshold neuron used in the TNN classifiers.
- Accepts one unsigned activation per cycle over a valid/ready stream and applies a compile-time ternary weight (+1/0/-1) chosen by element index.
- Accumulates a signed, saturating sum and emits one decision bit per vector of N_IN elements: 1 when sum > runtime threshold.
- Sits between the feature-quantisation front end and the class-vote stage, replacing hard-wired combinational neurons where area matters more than latency.

Parameters:
- IN_W, 2, activation width (unsigned).
- N_IN, 5, elements per vector (>=2).
- ACC_W, 6, signed accumulator/threshold width.
- WEIGHTS, 10'h1F5, packed 2*N_IN bits; element i at [2i+1:2i]. Codes: 01 = +1, 11 = -1, 00 = 0, 10 = 0 (reserved). Default gives elements 0,1,4 = +1 and 2,3 = -1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous abort of the partial vector.
- thr  in  ACC_W  signed threshold; sampled on the cycle the last element is accepted.
- in_valid  in  1  activation valid.
- in_ready  out  1  block can accept an activation.
- in_data  in  IN_W  unsigned activation.
- out_valid  out  1  decision available.
- out_ready  in  1  consumer accepts the decision.
- out_bit  out  1  decision: signed sum > thr.
- out_acc  out  ACC_W  final saturated signed sum (debug/chaining).

Behaviour:
- One clock domain (clk); rst is synchronous and active-high.
- Reset values: state=ACC, idx=0, acc=0, out_valid=0, out_bit=0, out_acc=0.
- in_ready = (state==ACC) && !rst. It is combinational on state and rst only, never on in_valid.
- Accept: in_valid && in_ready. term = +in_data, -in_data, or 0 per WEIGHTS[idx]. in_data is zero-extended to ACC_W+1 bits before negation.
- acc_next = sat(acc + term). The sum is computed at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Saturation is applied at every step and is sticky only through the arithmetic; no flag is generated.
- Non-last accept: acc <= acc_next; idx <= idx+1.
- Last accept (idx==N_IN-1): state <= DONE; out_valid <= 1 on the next edge; out_acc <= acc_next; out_bit <= (acc_next > thr), signed compare; acc <= 0; idx <= 0.
- Latency: out_valid rises 1 cycle after the last accept. Minimum period is N_IN+1 cycles per vector.
- DONE state: in_ready=0. out_valid, out_bit and out_acc hold stable until out_ready=1.
- Leaving DONE: on out_valid && out_ready, out_valid <= 0 and state <= ACC. in_ready=1 on the following cycle. No element is accepted in the handshake cycle.
- in_valid low or in_ready low: acc and idx hold.
- clear in ACC: acc <= 0 and idx <= 0; any element presented that cycle is dropped.
- clear in DONE: ignored; the pending result is preserved.
- clear takes priority over an accept in the same cycle.
- rst at any point, including mid-vector or in DONE: returns to reset values next edge. The pending output is discarded.
- Reserved weight code 10 behaves as 0. There are no X outputs for any WEIGHTS value.
- idx width is clog2(N_IN). idx never exceeds N_IN-1.

Test Plan:
- Default params, thr=0, stream 3,0,1,1,0 -> acc = 3-1-1 = 1; out_valid one cycle after 5th accept; out_bit=1, out_acc=1.
- Tie: stream 1,0,1,0,0 with thr=0 -> out_acc=0, out_bit=0. Repeat with thr=-1 -> out_bit=1.
- Backpressure: after a result, hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged. out_ready=1 -> out_valid falls next edge, in_ready=1 the cycle after. Next vector starts from acc=0.
- Saturation: ACC_W=4, stream 3,3,0,0,3 -> running sums clamp at 7; out_acc=7, out_bit=1 (thr=0). Stream 0,0,3,3,0 -> out_acc=-6, out_bit=0.
- Gaps and abort: stream 2,_,1 (in_valid low in gap), then clear with in_valid=1 and data 3, then 0,0,0,0,1 -> first elements discarded; result out_acc=1, out_bit=1.
- Reset mid-op: rst after 3 accepts -> in_ready=0 during rst, out_valid=0; next full vector 0,0,2,0,0 -> out_acc=-2, out_bit=0.
